// File: rtl/regfile_wb_queue_if.sv
`default_nettype none
// ============================================================================
// regfile_wb_queue_if : result-lane and register-file write-port bundle
// Revision 1.0
// ============================================================================
interface regfile_wb_queue_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int NR_WRITE_PORTS = 2
);
  logic [NR_WRITE_PORTS-1:0]                 in_valid_i;
  logic [NR_WRITE_PORTS-1:0][4:0]            in_addr_i;
  logic [NR_WRITE_PORTS-1:0][DATA_WIDTH-1:0] in_data_i;
  logic                                      in_ready_o;
  logic                                      stall_i;
  logic [NR_WRITE_PORTS-1:0]                 we_o;
  logic [NR_WRITE_PORTS-1:0][4:0]            waddr_o;
  logic [NR_WRITE_PORTS-1:0][DATA_WIDTH-1:0] wdata_o;

  modport master (
    output in_valid_i, in_addr_i, in_data_i, stall_i,
    input  in_ready_o, we_o, waddr_o, wdata_o
  );

  modport slave (
    input  in_valid_i, in_addr_i, in_data_i, stall_i,
    output in_ready_o, we_o, waddr_o, wdata_o
  );
endinterface
`default_nettype wire

// File: rtl/regfile_wb_queue.sv
`default_nettype none
// ============================================================================
// regfile_wb_queue : in-order write-back queue feeding the register-file ports
// Revision 1.0
// ============================================================================
module regfile_wb_queue #(
  parameter int DATA_WIDTH     = 32,
  parameter int NR_WRITE_PORTS = 2,
  parameter int DEPTH          = 8
) (
  input  wire logic                      clk_i,
  input  wire logic                      rst_i,
  input  wire logic                      flush_i,
  regfile_wb_queue_if.slave              bus,
  output logic [31:0]                    pend_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o,
  output logic                           empty_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] c_DEPTH = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] c_NRW   = CNT_W'(NR_WRITE_PORTS);
  localparam logic [CNT_W-1:0] c_ONE   = CNT_W'(1);

  logic [4:0]            r_addr [DEPTH];
  logic [DATA_WIDTH-1:0] r_data [DEPTH];
  logic [PTR_W-1:0]      r_head;
  logic [PTR_W-1:0]      r_tail;
  logic [CNT_W-1:0]      r_count;

  logic                                 w_ready;
  logic                                 w_push_en;
  logic                                 w_drain_en;
  logic [CNT_W-1:0]                     w_lane_cnt;
  logic [CNT_W-1:0]                     w_push_cnt;
  logic [CNT_W-1:0]                     w_pop_cnt;
  logic [NR_WRITE_PORTS-1:0]            w_lane_en;
  logic [NR_WRITE_PORTS-1:0][PTR_W-1:0] w_lane_slot;
  logic [PTR_W-1:0]                     w_age;
  logic [PTR_W-1:0]                     w_rd_slot;
  logic [31:0]                          w_pend;

  // Ready looks only at registered occupancy so it never depends on stall/flush.
  assign w_ready    = (c_DEPTH - r_count) >= c_NRW;
  assign w_push_en  = w_ready && !flush_i;
  assign w_drain_en = !bus.stall_i && !flush_i;
  assign w_push_cnt = w_push_en ? w_lane_cnt : '0;
  assign w_pop_cnt  = !w_drain_en ? '0 : ((r_count < c_NRW) ? r_count : c_NRW);

  // Compact valid, non-x0 lanes onto consecutive tail slots in lane order.
  always_comb begin
    w_lane_cnt  = '0;
    w_lane_en   = '0;
    w_lane_slot = '0;
    for (int l = 0; l < NR_WRITE_PORTS; l++) begin
      w_lane_slot[l] = r_tail + w_lane_cnt[PTR_W-1:0];
      if (bus.in_valid_i[l] && (bus.in_addr_i[l] != 5'd0)) begin
        w_lane_en[l] = w_push_en;
        w_lane_cnt   = w_lane_cnt + c_ONE;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + w_pop_cnt[PTR_W-1:0];
      r_tail  <= r_tail + w_push_cnt[PTR_W-1:0];
      r_count <= r_count + w_push_cnt - w_pop_cnt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int l = 0; l < NR_WRITE_PORTS; l++) begin
        if (w_lane_en[l]) begin
          r_addr[w_lane_slot[l]] <= bus.in_addr_i[l];
          r_data[w_lane_slot[l]] <= bus.in_data_i[l];
        end
      end
    end
  end

  // Oldest entry on port 0 so same-address collisions resolve youngest-wins.
  always_comb begin
    bus.we_o    = '0;
    bus.waddr_o = '0;
    bus.wdata_o = '0;
    w_rd_slot   = '0;
    for (int i = 0; i < NR_WRITE_PORTS; i++) begin
      w_rd_slot      = r_head + PTR_W'(i);
      bus.we_o[i]    = (CNT_W'(i) < r_count) && w_drain_en;
      bus.waddr_o[i] = r_addr[w_rd_slot];
      bus.wdata_o[i] = r_data[w_rd_slot];
    end
  end

  always_comb begin
    w_pend = '0;
    w_age  = '0;
    for (int j = 0; j < DEPTH; j++) begin
      w_age = PTR_W'(j) - r_head;
      if ({1'b0, w_age} < r_count) begin
        w_pend[r_addr[j]] = 1'b1;
      end
    end
    w_pend[0] = 1'b0;
  end

  assign bus.in_ready_o = w_ready;
  assign pend_o         = w_pend;
  assign count_o        = r_count;
  assign empty_o        = (r_count == '0);

endmodule
`default_nettype wire
